gcd_lcm_coproc: RTL

//  Multi-cycle GCD/LCM coprocessor fed by the main decoder's Start and ALU3SrcA (gcd/lcm select) controls.
//  It consumes rs1/rs2 operands and returns the result on the ResultSrc=2'b11 writeback path.

---
 rtl/gcd_lcm_coproc.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gcd_lcm_coproc.sv
// -----------------------------------------------------------------------------
// gcd_lcm_coproc
//   Multi-cycle GCD/LCM coprocessor for the integer pipeline. The decoder pulses
//   start with is_lcm selecting the function, and the coprocessor consumes the
//   rs1/rs2 operands. It holds the core via stall until the single DONE cycle,
//   when result is presented on the writeback path.
//
//   GCD  : binary (Stein) iteration, one step per cycle.
//   LCM  : (a / gcd) * b -- restoring divider (WIDTH cycles), then a shift-add
//          multiplier (WIDTH cycles) with a 2*WIDTH accumulator.
//
// Parameters
//   WIDTH    operand/result width (>= 4)
//
// Ports
//   clk      in   1      rising-edge clock
//   reset_n  in   1      synchronous active-low reset, aborts any operation
//   start    in   1      operation request, sampled only in IDLE
//   is_lcm   in   1      0 = gcd, 1 = lcm, latched with start
//   a, b     in   WIDTH  unsigned operands, latched with start
//   stall    out  1      core hold: start in IDLE, or any working state
//   busy     out  1      state != IDLE
//   done     out  1      high for the single DONE cycle
//   result   out  WIDTH  result, held from DONE until the next operation ends
//   ovf      out  1      (GCD_LCM_OVF_EN only) lcm product exceeded WIDTH bits;
//                        result is then saturated to all ones
//
// Build option
//   GCD_LCM_OVF_EN   adds the ovf output and saturation on lcm overflow.
//                    Without it the lcm result is truncated mod 2^WIDTH.
// -----------------------------------------------------------------------------
module gcd_lcm_coproc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_lcm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
`ifdef GCD_LCM_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GCD  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         r_state;
  logic               r_lcm;
  logic               r_zero;      // an operand was zero at start
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_x;         // Stein x, then the shifting dividend
  logic [WIDTH-1:0]   r_y;         // Stein y
  logic [CW-1:0]      r_k;         // common power of two removed from x, y
  logic [WIDTH-1:0]   r_g;         // gcd, used as divisor
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;       // quotient; shifted right as multiplier
  logic [2*WIDTH-1:0] r_mcand;     // multiplicand, shifted left each cycle
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_result;
`ifdef GCD_LCM_OVF_EN
  logic               r_ovf;
`endif

  // Stein step
  logic [WIDTH-1:0] w_x_step;
  logic [WIDTH-1:0] w_y_step;
  logic [CW-1:0]    w_k_step;
  logic [WIDTH-1:0] w_g;

  always_comb begin
    w_x_step = r_x;
    w_y_step = r_y;
    w_k_step = r_k;
    if (!r_x[0] && !r_y[0]) begin
      w_x_step = r_x >> 1;
      w_y_step = r_y >> 1;
      w_k_step = r_k + CW'(1);
    end else if (!r_x[0]) begin
      w_x_step = r_x >> 1;
    end else if (!r_y[0]) begin
      w_y_step = r_y >> 1;
    end else if (r_x > r_y) begin
      w_x_step = r_x - r_y;
    end else begin
      w_y_step = r_y - r_x;
    end
  end

  // Only meaningful once x == y
  assign w_g = r_x << r_k;

  // Restoring divide step: bring in the next dividend bit, subtract if it fits.
  // The trial value needs one extra bit because rem < g can still reach
  // 2^WIDTH - 2 before the shift.
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH:0]   w_div_sub;
  logic [WIDTH-1:0] w_rem_next;

  assign w_div_shift = {r_rem, r_x[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_g});
  assign w_div_sub   = w_div_shift - {1'b0, r_g};
  // After a restoring step the remainder is always < g, so WIDTH bits suffice
  assign w_rem_next  = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_shift[WIDTH-1:0];

  // Shift-add multiply step
  logic [2*WIDTH-1:0] w_acc_next;
  assign w_acc_next = r_acc + (r_quo[0] ? r_mcand : {(2*WIDTH){1'b0}});

  // Final lcm value as written to result
  logic [WIDTH-1:0] w_lcm_result;
`ifdef GCD_LCM_OVF_EN
  logic w_ovf;
  assign w_ovf        = |w_acc_next[2*WIDTH-1:WIDTH];
  assign w_lcm_result = w_ovf ? {WIDTH{1'b1}} : w_acc_next[WIDTH-1:0];
`else
  assign w_lcm_result = w_acc_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_lcm    <= 1'b0;
      r_zero   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_k      <= '0;
      r_g      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
`ifdef GCD_LCM_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lcm   <= is_lcm;
            r_zero  <= (a == '0) || (b == '0);
            r_a     <= a;
            r_b     <= b;
            r_x     <= a;
            r_y     <= b;
            r_k     <= '0;
            r_state <= S_GCD;
          end
        end

        S_GCD: begin
          if (r_zero) begin
            // Zero operand: Stein would never converge, so finish directly.
            // x|y is the nonzero operand, or 0 for gcd(0,0).
            r_result <= r_lcm ? '0 : (r_x | r_y);
`ifdef GCD_LCM_OVF_EN
            r_ovf    <= 1'b0;
`endif
            r_state  <= S_DONE;
          end else if (r_x == r_y) begin
            if (!r_lcm) begin
              r_result <= w_g;
`ifdef GCD_LCM_OVF_EN
              r_ovf    <= 1'b0;
`endif
              r_state  <= S_DONE;
            end else begin
              r_g     <= w_g;
              r_x     <= r_a;
              r_rem   <= '0;
              r_quo   <= '0;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end
          end else begin
            r_x <= w_x_step;
            r_y <= w_y_step;
            r_k <= w_k_step;
          end
        end

        S_DIV: begin
          r_rem <= w_rem_next;
          r_x   <= r_x << 1;
          r_quo <= {r_quo[WIDTH-2:0], w_div_ge};
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, r_b};
            r_state <= S_MUL;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_MUL: begin
          r_acc   <= w_acc_next;
          r_quo   <= r_quo >> 1;
          r_mcand <= r_mcand << 1;
          if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_result <= w_lcm_result;
`ifdef GCD_LCM_OVF_EN
            r_ovf    <= w_ovf;
`endif
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign stall  = (start && (r_state == S_IDLE)) ||
                  ((r_state != S_IDLE) && (r_state != S_DONE));
  assign result = r_result;
`ifdef GCD_LCM_OVF_EN
  assign ovf    = r_ovf;
`endif

endmodule
